// File: rtl/adc_avg_pkg.sv
// Shared definitions for the ADC sample averager: default widths and the
// block-average helper used when a block of samples completes.
package adc_avg_pkg;

  localparam int NUM_BITS_DEF   = 4;
  localparam int LOG2_AVG_DEF   = 2;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int ACC_W          = NUM_BITS_DEF + LOG2_AVG_DEF;
  localparam int LVL_W          = $clog2(FIFO_DEPTH_DEF) + 1;

  // Truncating average of the running sum plus the closing sample.
  function automatic logic [31:0] avg_of(input logic [31:0] acc,
                                         input logic [31:0] d_in,
                                         input int unsigned log2_avg);
    return (acc + d_in) >> log2_avg;
  endfunction

endpackage

// File: rtl/adc_avg_fifo.sv
// Small synchronous FIFO for averaged codes; extra pointer MSB separates full
// from empty, and the head is read straight from the array (0 when empty).
module adc_avg_fifo
  import adc_avg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign level = wr_ptr_reg - rd_ptr_reg;
  assign head  = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty && !clr;
  assign do_push = push && (!full || do_pop) && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

endmodule

// File: rtl/adc_sample_averager.sv
// Captures ADC codes on the rising edge of eoc, block-averages 2^LOG2_AVG
// samples and queues the results for a valid/ready consumer.
module adc_sample_averager
  import adc_avg_pkg::*;
#(
  parameter int NUM_BITS   = NUM_BITS_DEF,
  parameter int LOG2_AVG   = LOG2_AVG_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic [NUM_BITS-1:0]           d_in,
  input  logic                          eoc,
  output logic [NUM_BITS-1:0]           dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int ACC_BITS = NUM_BITS + LOG2_AVG;

  logic                eoc_q_reg;
  logic                capture;
  logic                push_req;
  logic [NUM_BITS-1:0] push_data;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic                overflow_reg;

  // eoc_q keeps following eoc even while clr is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) eoc_q_reg <= 1'b0;
    else        eoc_q_reg <= eoc;
  end

  assign capture = eoc && !eoc_q_reg;

  if (LOG2_AVG == 0) begin : g_pass
    assign push_req  = capture && !clr;
    assign push_data = d_in;
  end else begin : g_avg
    logic [ACC_BITS-1:0] acc_reg;
    logic [LOG2_AVG-1:0] cnt_reg;
    logic                block_done;

    assign block_done = capture && (cnt_reg == {LOG2_AVG{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_reg <= '0;
        cnt_reg <= '0;
      end else if (clr) begin
        acc_reg <= '0;
        cnt_reg <= '0;
      end else if (capture) begin
        // The accumulator restarts even if the FIFO drops this average.
        if (block_done) begin
          acc_reg <= '0;
          cnt_reg <= '0;
        end else begin
          acc_reg <= acc_reg + ACC_BITS'(d_in);
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end

    assign push_req  = block_done && !clr;
    assign push_data = NUM_BITS'(avg_of(32'(acc_reg), 32'(d_in), LOG2_AVG));
  end

  assign dout_valid = !fifo_empty;
  assign fifo_pop   = dout_valid && dout_ready;

  adc_avg_fifo #(
    .WIDTH (NUM_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (push_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level),
    .head  (dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     overflow_reg <= 1'b0;
    else if (clr)                                   overflow_reg <= 1'b0;
    else if (push_req && fifo_full && !fifo_pop)    overflow_reg <= 1'b1;
  end

  assign overflow = overflow_reg;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Bench for adc_sample_averager: table of 4-sample blocks plus hand-written
// corner sequences; expected averages are queued at stimulus and popped on handshake.
module tb_adc_sample_averager;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       eoc = 1'b0;
  logic       dout_ready = 1'b0;
  logic       dout_ready0 = 1'b1;
  logic [3:0] d_in = 4'd0;
  logic [3:0] dout, dout0;
  logic       dout_valid, dout_valid0;
  logic       overflow, overflow0;
  logic [2:0] fifo_level, fifo_level0;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  typedef struct {
    int c0; int c1; int c2; int c3; int avg;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  adc_sample_averager #(.NUM_BITS(4), .LOG2_AVG(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .d_in(d_in), .eoc(eoc),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  adc_sample_averager #(.NUM_BITS(4), .LOG2_AVG(0), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .d_in(d_in), .eoc(eoc),
    .dout(dout0), .dout_valid(dout_valid0), .dout_ready(dout_ready0),
    .overflow(overflow0), .fifo_level(fifo_level0)
  );

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // One-cycle eoc pulse followed by one low cycle.
  task automatic capture(input int code, input bit push_exp, input int expv);
    @(negedge clk);
    eoc  = 1'b1;
    d_in = code[3:0];
    if (push_exp) exp_q.push_back(expv);
    @(negedge clk);
    eoc = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Scoreboard: every accepted handshake must match the oldest expectation.
  always @(negedge clk) begin
    #1;
    if (rst_n && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pop: got %0d, expected no output", dout);
      end else begin
        chk("scoreboard_pop", dout, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{3, 5, 7, 9, 6};
    tbl[1] = '{15, 15, 15, 14, 14};
    tbl[2] = '{0, 0, 0, 0, 0};
    tbl[3] = '{15, 15, 15, 15, 15};
    tbl[4] = '{1, 2, 3, 4, 2};
    tbl[5] = '{8, 0, 0, 0, 2};

    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_level", fifo_level, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", dout_valid, 0);

    // Table-driven blocks with the consumer always ready
    dout_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      capture(tbl[i].c0, 0, 0);
      capture(tbl[i].c1, 0, 0);
      capture(tbl[i].c2, 0, 0);
      chk("vec_no_early_valid", dout_valid, 0);
      capture(tbl[i].c3, 1, tbl[i].avg);
      chk("vec_dout", dout, tbl[i].avg);
      chk("vec_valid", dout_valid, 1);
      chk("vec_level", fifo_level, 1);
      @(negedge clk);
      chk("vec_level_drained", fifo_level, 0);
    end

    // Held eoc counts once; consumer stalled so any extra push would stay visible
    dout_ready = 1'b0;
    @(negedge clk);
    eoc  = 1'b1;
    d_in = 4'd8;
    repeat (10) @(negedge clk);
    eoc = 1'b0;
    chk("hold_one_capture", dout_valid, 0);
    capture(8, 0, 0);
    capture(8, 0, 0);
    chk("hold_not_early", dout_valid, 0);
    capture(8, 1, 8);
    chk("hold_avg_dout", dout, 8);
    chk("hold_avg_level", fifo_level, 1);
    dout_ready = 1'b1;
    @(negedge clk);
    chk("hold_drained", fifo_level, 0);

    // Overflow: five blocks into a four-entry FIFO with no consumer
    pulse_clr();
    dout_ready = 1'b0;
    for (int b = 0; b < 5; b++) begin
      capture(2, 0, 0);
      capture(2, 0, 0);
      capture(2, 0, 0);
      capture(2, b < 4, 2);
    end
    chk("ovf_level", fifo_level, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", dout, 2);
    dout_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("ovf_drain_valid", dout_valid, 0);
    chk("ovf_drain_dout", dout, 0);
    chk("ovf_drain_level", fifo_level, 0);
    chk("ovf_sticky", overflow, 1);
    pulse_clr();
    chk("clr_overflow", overflow, 0);

    // Full FIFO with push and pop in the same cycle
    dout_ready = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      capture(v, 0, 0);
      capture(v, 0, 0);
      capture(v, 0, 0);
      capture(v, 1, v);
    end
    chk("full_level", fifo_level, 4);
    capture(5, 0, 0);
    capture(5, 0, 0);
    capture(5, 0, 0);
    @(negedge clk);
    eoc        = 1'b1;
    d_in       = 4'd5;
    dout_ready = 1'b1;
    exp_q.push_back(5);
    @(negedge clk);
    eoc        = 1'b0;
    dout_ready = 1'b0;
    chk("pushpop_level", fifo_level, 4);
    chk("pushpop_overflow", overflow, 0);
    chk("pushpop_head", dout, 2);
    dout_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("pushpop_drained", fifo_level, 0);

    // Async reset with a queued entry and a half-filled block
    dout_ready = 1'b0;
    capture(3, 0, 0);
    capture(3, 0, 0);
    capture(3, 0, 0);
    capture(3, 0, 0);
    capture(7, 0, 0);
    capture(7, 0, 0);
    chk("pre_rst_level", fifo_level, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", dout_valid, 0);
    chk("midrst_dout", dout, 0);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_overflow", overflow, 0);
    @(negedge clk);
    rst_n      = 1'b1;
    dout_ready = 1'b1;
    capture(1, 0, 0);
    capture(1, 0, 0);
    capture(1, 0, 0);
    capture(1, 1, 1);
    chk("after_rst_dout", dout, 1);
    @(negedge clk);

    // clr mid-block discards the partial sum
    capture(9, 0, 0);
    capture(9, 0, 0);
    pulse_clr();
    chk("clr_valid", dout_valid, 0);
    chk("clr_level", fifo_level, 0);
    capture(1, 0, 0);
    capture(1, 0, 0);
    capture(1, 0, 0);
    chk("clr_no_early", dout_valid, 0);
    capture(1, 1, 1);
    chk("after_clr_dout", dout, 1);
    @(negedge clk);

    // Pass-through build: each capture is queued unchanged
    pulse_clr();
    for (int k = 0; k < 3; k++) begin
      int code;
      code = (k == 2) ? 6 : 11;
      capture(code, 0, 0);
      chk("pass_dout", dout0, code);
      chk("pass_valid", dout_valid0, 1);
      @(negedge clk);
      chk("pass_drained", dout_valid0, 0);
    end
    chk("pass_overflow", overflow0, 0);
    pulse_clr();

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
